// File: rtl/digit_scan_driver.sv
// Time-multiplexed N-digit display scanner with tear-free, frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module digit_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [3:0]              digit_val,
  output logic [4*NUM_DIGITS-1:0] digit_mask,
  output logic                    digit_blank,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [DW-1:0] pending_q_reg, pending_q_next;
  logic [DW-1:0] display_q_reg, display_q_next;
  logic          pending_reg, pending_next;
  logic          frame_done_reg, frame_done_next;
  logic          advance, wrap;

  always_comb begin
    advance         = enable && (cnt_reg == CW'(REFRESH_DIV - 1));
    wrap            = advance && (idx_reg == IW'(NUM_DIGITS - 1));
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    frame_done_next = wrap;
    if (enable) begin
      if (advance) begin
        cnt_next = '0;
        idx_next = wrap ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    // A load coinciding with the wrap bypasses the pending stage so the newest value wins.
    pending_q_next = pending_q_reg;
    pending_next   = pending_reg;
    display_q_next = display_q_reg;
    if (load) begin
      pending_q_next = value_in;
      if (wrap) begin
        display_q_next = value_in;
        pending_next   = 1'b0;
      end else begin
        pending_next   = 1'b1;
      end
    end else if (wrap && pending_reg) begin
      display_q_next = pending_q_reg;
      pending_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pending_q_reg  <= '0;
      pending_reg    <= 1'b0;
      display_q_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      pending_q_reg  <= pending_q_next;
      pending_reg    <= pending_next;
      display_q_reg  <= display_q_next;
      frame_done_reg <= frame_done_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_sel[gi]          = (idx_reg == IW'(gi));
      assign digit_mask[4*gi +: 4]  = (idx_reg == IW'(gi)) ? 4'hF : 4'h0;
    end
  endgenerate

  assign digit_val      = display_q_reg[{idx_reg, 2'b00} +: 4];
  assign frame_done     = frame_done_reg;
  assign update_pending = pending_reg;

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Walk from the most significant digit down; blank if everything from idx upward is zero.
  always_comb begin
    upper_zero  = 1'b1;
    digit_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (display_q_reg[4*i +: 4] == 4'h0);
      if (idx_reg == IW'(i)) digit_blank = upper_zero;
    end
  end
`else
  assign digit_blank = 1'b0;
`endif

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4); each task checks one scenario.
module tb_digit_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  digit_sel;
  logic [3:0]  digit_val;
  logic [15:0] digit_mask;
  logic        digit_blank;
  logic        frame_done;
  logic        update_pending;

  int n_cmp = 0;
  int n_bad = 0;
  int ph = 0;  // enabled cycles since reset release; idx = (ph/4)%4

  digit_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value_in(value_in),
    .digit_sel(digit_sel), .digit_val(digit_val), .digit_mask(digit_mask),
    .digit_blank(digit_blank), .frame_done(frame_done), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    if (enable && rst_n) ph++;
    #1;
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i < 16; i++) begin
      if (ph % 16 == p) break;
      step();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (digit_sel !== 4'b0001) begin n_bad++; $display("FAIL reset_sel: got %b expected 0001", digit_sel); end
    n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL reset_val: got %h expected 0", digit_val); end
    n_cmp++; if (digit_mask !== 16'h000F) begin n_bad++; $display("FAIL reset_mask: got %h expected 000f", digit_mask); end
    n_cmp++; if (digit_blank !== 1'b0) begin n_bad++; $display("FAIL reset_blank: got %b expected 0", digit_blank); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    n_cmp++; if (update_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pend: got %b expected 0", update_pending); end
    rst_n = 1'b1;
    ph = 0;
    $display("reset: released");
  endtask

  task automatic test_scan();
    int pulses;
    int ei;
    logic [3:0]  es;
    logic [15:0] em;
    pulses = 0;
    enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      ei = (ph / 4) % 4;
      es = 4'b0001 << ei;
      em = 16'h000F << (4 * ei);
      if (frame_done === 1'b1) pulses++;
      n_cmp++; if (digit_sel !== es) begin n_bad++; $display("FAIL scan_sel ph=%0d: got %b expected %b", ph, digit_sel, es); end
      n_cmp++; if (digit_mask !== em) begin n_bad++; $display("FAIL scan_mask ph=%0d: got %h expected %h", ph, digit_mask, em); end
      n_cmp++; if (frame_done !== (ph % 16 == 0)) begin n_bad++; $display("FAIL scan_fd ph=%0d: got %b expected %b", ph, frame_done, (ph % 16 == 0)); end
    end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL scan_pulses: got %0d expected 2", pulses); end
    $display("scan: 32 cycles, %0d frame_done pulses", pulses);
  endtask

  task automatic test_load_midframe();
    logic [15:0] exp_disp;
    int ei;
    exp_disp = 16'h1234;
    goto_phase(4);
    load = 1'b1; value_in = 16'h1234;
    step();
    load = 1'b0;
    $display("load: 0x1234 at idx 1");
    n_cmp++; if (update_pending !== 1'b1) begin n_bad++; $display("FAIL mid_pend: got %b expected 1", update_pending); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL mid_val_before ph=%0d: got %h expected 0", ph, digit_val); end
      step();
      if (ph % 16 == 0) break;
    end
    n_cmp++; if (update_pending !== 1'b0) begin n_bad++; $display("FAIL mid_pend_after: got %b expected 0", update_pending); end
    for (int i = 0; i < 16; i++) begin
      ei = (ph / 4) % 4;
      n_cmp++; if (digit_val !== exp_disp[4*ei +: 4]) begin n_bad++; $display("FAIL mid_val idx=%0d: got %h expected %h", ei, digit_val, exp_disp[4*ei +: 4]); end
      step();
    end
  endtask

  task automatic test_last_wins();
    logic [15:0] old_disp;
    int ei;
    old_disp = 16'h1234;
    goto_phase(2);
    load = 1'b1; value_in = 16'hAAAA;
    step();
    value_in = 16'h5555;
    step();
    load = 1'b0;
    $display("load: 0xAAAA then 0x5555 in one frame");
    ei = (ph / 4) % 4;
    n_cmp++; if (update_pending !== 1'b1) begin n_bad++; $display("FAIL last_pend: got %b expected 1", update_pending); end
    n_cmp++; if (digit_val !== old_disp[4*ei +: 4]) begin n_bad++; $display("FAIL last_old_val: got %h expected %h", digit_val, old_disp[4*ei +: 4]); end
    goto_phase(0);
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (digit_val !== 4'h5) begin n_bad++; $display("FAIL last_val ph=%0d: got %h expected 5", ph, digit_val); end
      step();
    end
  endtask

  task automatic test_coincident();
    logic [15:0] exp_disp;
    int ei;
    exp_disp = 16'h9876;
    goto_phase(15);
    load = 1'b1; value_in = 16'h9876;
    step();
    load = 1'b0;
    $display("load: 0x9876 on wrap edge");
    n_cmp++; if (update_pending !== 1'b0) begin n_bad++; $display("FAIL coin_pend: got %b expected 0", update_pending); end
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL coin_fd: got %b expected 1", frame_done); end
    for (int i = 0; i < 16; i++) begin
      ei = (ph / 4) % 4;
      n_cmp++; if (digit_val !== exp_disp[4*ei +: 4]) begin n_bad++; $display("FAIL coin_val idx=%0d: got %h expected %h", ei, digit_val, exp_disp[4*ei +: 4]); end
      step();
    end
  endtask

  task automatic test_enable_hold();
    logic [15:0] exp_disp;
    logic [3:0]  es;
    int ei;
    exp_disp = 16'hBEEF;
    goto_phase(8);
    enable = 1'b0;
    load = 1'b1; value_in = 16'hBEEF;
    step();
    load = 1'b0;
    $display("load: 0xBEEF while disabled at idx 2");
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (digit_sel !== 4'b0100) begin n_bad++; $display("FAIL hold_sel: got %b expected 0100", digit_sel); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL hold_fd: got %b expected 0", frame_done); end
      n_cmp++; if (update_pending !== 1'b1) begin n_bad++; $display("FAIL hold_pend: got %b expected 1", update_pending); end
      n_cmp++; if (digit_val !== 4'h8) begin n_bad++; $display("FAIL hold_val: got %h expected 8", digit_val); end
      step();
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ph % 16 == 0) break;
      es = 4'b0001 << ((ph / 4) % 4);
      n_cmp++; if (digit_sel !== es) begin n_bad++; $display("FAIL resume_sel ph=%0d: got %b expected %b", ph, digit_sel, es); end
      n_cmp++; if (update_pending !== 1'b1) begin n_bad++; $display("FAIL resume_pend ph=%0d: got %b expected 1", ph, update_pending); end
    end
    n_cmp++; if (update_pending !== 1'b0) begin n_bad++; $display("FAIL resume_pend_after: got %b expected 0", update_pending); end
    for (int i = 0; i < 16; i++) begin
      ei = (ph / 4) % 4;
      n_cmp++; if (digit_val !== exp_disp[4*ei +: 4]) begin n_bad++; $display("FAIL resume_val idx=%0d: got %h expected %h", ei, digit_val, exp_disp[4*ei +: 4]); end
      step();
    end
  endtask

  task automatic test_async_reset();
    goto_phase(12);
    load = 1'b1; value_in = 16'h4321;
    step();
    load = 1'b0;
    n_cmp++; if (update_pending !== 1'b1) begin n_bad++; $display("FAIL ar_pend_before: got %b expected 1", update_pending); end
    n_cmp++; if (digit_sel !== 4'b1000) begin n_bad++; $display("FAIL ar_sel_before: got %b expected 1000", digit_sel); end
    #2 rst_n = 1'b0;
    #1;
    $display("reset: asserted mid-cycle at idx 3 with update pending");
    n_cmp++; if (digit_sel !== 4'b0001) begin n_bad++; $display("FAIL ar_sel: got %b expected 0001", digit_sel); end
    n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL ar_val: got %h expected 0", digit_val); end
    n_cmp++; if (digit_mask !== 16'h000F) begin n_bad++; $display("FAIL ar_mask: got %h expected 000f", digit_mask); end
    n_cmp++; if (update_pending !== 1'b0) begin n_bad++; $display("FAIL ar_pend: got %b expected 0", update_pending); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL ar_fd: got %b expected 0", frame_done); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ph = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL ar_val_after ph=%0d: got %h expected 0", ph, digit_val); end
      n_cmp++; if (update_pending !== 1'b0) begin n_bad++; $display("FAIL ar_pend_after ph=%0d: got %b expected 0", ph, update_pending); end
    end
  endtask

  task automatic test_blank();
    logic [15:0] disp [2];
    logic [3:0]  pat  [2];
    int ei;
    disp[0] = 16'h0050;
    disp[1] = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
    pat[0] = 4'b1100;
    pat[1] = 4'b1110;
`else
    pat[0] = 4'b0000;
    pat[1] = 4'b0000;
`endif
    for (int t = 0; t < 2; t++) begin
      goto_phase(15);
      load = 1'b1; value_in = disp[t];
      step();
      load = 1'b0;
      $display("blank: display 0x%h", disp[t]);
      for (int i = 0; i < 16; i++) begin
        ei = (ph / 4) % 4;
        n_cmp++; if (digit_blank !== pat[t][ei]) begin n_bad++; $display("FAIL blank idx=%0d disp=%h: got %b expected %b", ei, disp[t], digit_blank, pat[t][ei]); end
        n_cmp++; if (digit_val !== disp[t][4*ei +: 4]) begin n_bad++; $display("FAIL blank_val idx=%0d: got %h expected %h", ei, digit_val, disp[t][4*ei +: 4]); end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_last_wins();
    test_coincident();
    test_enable_hold();
    test_async_reset();
    test_blank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
